prbs_checker: RTL and testbench

//  Receive-side checker for the 5-bit LFSR pattern generator.
//  - Takes LFSR words and self-synchronises to the sequence.
//  - Flags and counts every word that deviates from the predicted next value.
//  - Sits after the clock-domain crossing, in the fast domain.
//  - Used as the BER monitor for the modulation path.

---
 rtl/prbs_checker_if.sv | 35 +++
 rtl/prbs_checker.sv | 139 +++++++++++++
 tb/tb_prbs_checker.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/prbs_checker_if.sv
// prbs_checker_if: word stream and status bundle for prbs_checker.
//   master (source side): drives valid, data, clr_cnt; observes status.
//   slave  (checker side): receives valid, data, clr_cnt; drives status.
//   valid     1      data word present this cycle
//   data      W      received LFSR word
//   clr_cnt   1      synchronous clear of the counters
//   locked    1      checker synchronised to the sequence
//   err_pulse 1      one-cycle strobe on a mispredicted word while locked
//   err_cnt   CNT_W  saturating error count
//   word_cnt  CNT_W  saturating locked word count (CHK_STATS_EN only)
// Optional feature macro: CHK_STATS_EN
interface prbs_checker_if #(
  parameter int unsigned W     = 5,
  parameter int unsigned CNT_W = 16
);
  logic             valid;
  logic [W-1:0]     data;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;
`ifdef CHK_STATS_EN
  logic [CNT_W-1:0] word_cnt;

  modport master (output valid, data, clr_cnt,
                  input  locked, err_pulse, err_cnt, word_cnt);
  modport slave  (input  valid, data, clr_cnt,
                  output locked, err_pulse, err_cnt, word_cnt);
`else
  modport master (output valid, data, clr_cnt,
                  input  locked, err_pulse, err_cnt);
  modport slave  (input  valid, data, clr_cnt,
                  output locked, err_pulse, err_cnt);
`endif
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: receive-side checker for the W-bit LFSR pattern generator.
// Self-synchronises to the incoming sequence, then flags and counts every
// word that deviates from the predicted next value. All outputs registered.
//   clk  in  sole clock, rising edge
//   rst  in  synchronous, active-high reset
//   bus  slave modport of prbs_checker_if (valid/data/clr_cnt in;
//        locked/err_pulse/err_cnt[/word_cnt] out)
// Optional feature macro: CHK_STATS_EN (adds the locked word counter).
module prbs_checker #(
  parameter int unsigned W        = 5,
  parameter logic [W-1:0] TAPS    = W'(5'b10100),
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned MISS_MAX = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic clk,
  input  logic rst,
  prbs_checker_if.slave bus
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned RW = $clog2(MISS_MAX + 1);

  typedef enum logic {HUNT, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     exp_q, exp_d;
  logic [MW-1:0]    match_q, match_d;
  logic [RW-1:0]    miss_q, miss_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [W-1:0]     nxt;
  logic             err_inc;

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
    return {s[W-2:0], ^(s & TAPS)};
  endfunction

  assign nxt = lfsr_next(exp_q);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    pulse_d = 1'b0;
    err_inc = 1'b0;
    if (bus.valid) begin
      case (state_q)
        HUNT: begin
          if (bus.data == '0) begin
            // all-zero lockup word: never a seed, breaks the match run
            match_d = '0;
          end else if (exp_q != '0 && bus.data == nxt) begin
            exp_d = bus.data;
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            exp_d   = bus.data;
            match_d = '0;
          end
        end
        LOCKED: begin
          // generator is free-running: prediction never reseeds from data
          exp_d = nxt;
          if (bus.data != nxt) begin
            pulse_d = 1'b1;
            err_inc = 1'b1;
            if (miss_q == RW'(MISS_MAX - 1)) begin
              state_d = HUNT;
              exp_d   = bus.data;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // clear takes priority over a same-cycle error
    err_d = err_q;
    if (bus.clr_cnt)
      err_d = '0;
    else if (err_inc && err_q != '1)
      err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      exp_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      pulse_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_pulse = pulse_q;
  assign bus.err_cnt   = err_q;

`ifdef CHK_STATS_EN
  logic [CNT_W-1:0] wc_q, wc_d;

  always_comb begin
    wc_d = wc_q;
    if (bus.clr_cnt)
      wc_d = '0;
    else if (bus.valid && state_q == LOCKED && wc_q != '1)
      wc_d = wc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wc_q <= '0;
    else     wc_q <= wc_d;
  end

  assign bus.word_cnt = wc_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed stimulus pushes hand-derived expected
// outputs into a scoreboard queue; a monitor pops and compares each cycle.
module tb_prbs_checker;
  localparam int unsigned W  = 5;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prbs_checker_if #(.W(W), .CNT_W(CW)) bus ();
  prbs_checker #(.W(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int   tag;
    logic lk;
    logic ep;
    int   ec;
    int   ew;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int tag   = 0;
  int p     = 0;

  // full period of next(s) = {s[3:0], s[4]^s[2]} starting at 00001
  logic [4:0] seq [0:30];

  task automatic chk(input string nm, input int tg, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s step=%0d actual=%0d required=%0d", nm, tg, act, req);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic c, input logic [4:0] d,
                      input logic lk, input logic ep, input int ec, input int ew);
    @(negedge clk);
    rst         = r;
    bus.valid   = v;
    bus.clr_cnt = c;
    bus.data    = d;
    tag++;
    sb.push_back('{tag, lk, ep, ec, ew});
  endtask

  task automatic good(input logic lk, input int ec, input int ew);
    step(1'b0, 1'b1, 1'b0, seq[p], lk, 1'b0, ec, ew);
    p = (p + 1) % 31;
  endtask

  task automatic wrong(input logic lk, input logic c, input int ec);
    step(1'b0, 1'b1, c, seq[p] ^ 5'b00001, lk, 1'b1, ec, -1);
    p = (p + 1) % 31;
  endtask

  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("locked", e.tag, int'(bus.locked), int'(e.lk));
        chk("err_pulse", e.tag, int'(bus.err_pulse), int'(e.ep));
        chk("err_cnt", e.tag, int'(bus.err_cnt), e.ec);
`ifdef CHK_STATS_EN
        if (e.ew >= 0) chk("word_cnt", e.tag, int'(bus.word_cnt), e.ew);
`endif
      end
    end
  end

  initial begin
    seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101, 5'b01011,
            5'b10110, 5'b01100, 5'b11001, 5'b10011, 5'b00111, 5'b01111, 5'b11111,
            5'b11110, 5'b11100, 5'b11000, 5'b10001, 5'b00011, 5'b00110, 5'b01101,
            5'b11011, 5'b10111, 5'b01110, 5'b11101, 5'b11010, 5'b10101, 5'b01010,
            5'b10100, 5'b01000, 5'b10000};
    rst = 1'b1; bus.valid = 1'b0; bus.clr_cnt = 1'b0; bus.data = '0;

    // reset state, then lock on five words of the sequence
    step(1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 5'b01001, 1'b0, 1'b0, 0, 0);
    p = 0;
    for (int i = 0; i < 5; i++) good(i == 4, 0, 0);

    // single wrong word in place of 00101, then the correct continuation
    step(1'b0, 1'b1, 1'b0, 5'b01011, 1'b1, 1'b1, 1, -1);
    p = 6;
    for (int i = 0; i < 3; i++) good(1'b1, 1, -1);
    // valid gaps with garbage data while locked
    step(1'b0, 1'b0, 1'b0, 5'b10101, 1'b1, 1'b0, 1, -1);
    step(1'b0, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 1, -1);
    for (int i = 0; i < 2; i++) good(1'b1, 1, -1);

    // three consecutive misses drop lock; relock after five clean words
    step(1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b1, 2, -1);
    step(1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b1, 3, -1);
    step(1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b1, 4, -1);
    p = 13;
    for (int i = 0; i < 5; i++) good(i == 4, 4, -1);

    // drop lock again, then a stream of zeros while hunting
    step(1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b1, 5, -1);
    step(1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b1, 6, -1);
    step(1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b1, 7, -1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 7, -1);
    // a zero word mid-hunt restarts the match run
    p = 0;
    for (int i = 0; i < 3; i++) good(1'b0, 7, -1);
    step(1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 7, -1);
    for (int i = 0; i < 3; i++) good(1'b0, 7, -1);
    good(1'b1, 7, -1);

    // clear alone, then saturate the 4-bit error counter
    step(1'b0, 1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 0, -1);
    for (int k = 0; k < 20; k++) begin
      wrong(1'b1, 1'b0, (k + 1 > 15) ? 15 : k + 1);
      good(1'b1, (k + 1 > 15) ? 15 : k + 1, -1);
    end
    // clear concurrent with an error: counter clears, strobe still fires
    wrong(1'b1, 1'b1, 0);
    good(1'b1, 0, -1);

    // reset while locked with err_cnt=2
    wrong(1'b1, 1'b0, 1);
    good(1'b1, 1, -1);
    wrong(1'b1, 1'b0, 2);
    step(1'b1, 1'b1, 1'b0, seq[p], 1'b0, 1'b0, 0, 0);
    p = 0;
    for (int i = 0; i < 5; i++) good(i == 4, 0, 0);
    for (int i = 1; i <= 3; i++) good(1'b1, 0, i);

    @(negedge clk);
    bus.valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
